fanout_fork_ctrl: RTL

FANOUT_FORK_CTRL -- requirements
Module: fanout_fork_ctrl

---
 rtl/fanout_fork_ctrl_if.sv | 29 ++
 rtl/fanout_fork_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fanout_fork_ctrl_if.sv
// fanout_fork_ctrl_if
// Handshake bundle between one producer, the fork and NUM_OUT consumers.
//   in_data/in_valid/in_ready    : producer side token handshake
//   out_data                     : held token, broadcast to every consumer
//   out_valid/out_ready          : one valid/ready pair per consumer
// Modports:
//   master : the surrounding environment (drives producer token and consumer readies)
//   slave  : the fork itself
interface fanout_fork_ctrl_if #(
  parameter int NUM_OUT = 6,
  parameter int DATA_W  = 16
);
  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  out_data;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/fanout_fork_ctrl.sv
// fanout_fork_ctrl
// One-entry fork: accepts a producer token, holds it and offers it to every
// enabled consumer. Each consumer takes the token exactly once; when every
// enabled consumer has taken it the token is released and a new one may be
// loaded in that same cycle, giving one token per cycle when all are ready.
// Ports:
//   CLK         : clock, rising edge
//   ASYNCRESET  : asynchronous active-high reset
//   flush       : synchronous drop of the held token (tok_count untouched)
//   cfg_en_mask : per-consumer participation enable, evaluated every cycle
//   bus         : producer/consumer handshakes (slave modport)
//   tok_count   : number of released tokens, wraps at 16 bits
//   busy        : a token is held
module fanout_fork_ctrl #(
  parameter int NUM_OUT = 6,
  parameter int DATA_W  = 16
) (
  input  logic               CLK,
  input  logic               ASYNCRESET,
  input  logic               flush,
  input  logic [NUM_OUT-1:0] cfg_en_mask,
  fanout_fork_ctrl_if.slave  bus,
  output logic [15:0]        tok_count,
  output logic               busy
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [DATA_W-1:0]  data_reg, data_next;
  logic [NUM_OUT-1:0] done_reg, done_next;
  logic [15:0]        count_reg, count_next;

  logic               full;
  logic [NUM_OUT-1:0] out_valid_w;
  logic [NUM_OUT-1:0] out_fire;
  logic [NUM_OUT-1:0] taken;
  logic               tok_release;
  logic               in_ready_w;
  logic               in_fire;

  assign full = (state_reg == ST_FULL);

  // A consumer counts as having taken the token if it is disabled right now,
  // already took it earlier, or takes it this cycle. Disabling a consumer
  // mid-token therefore lets the token release without it.
  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_port
      assign out_valid_w[gi] = full & cfg_en_mask[gi] & ~done_reg[gi];
      assign out_fire[gi]    = out_valid_w[gi] & bus.out_ready[gi];
      assign taken[gi]       = ~cfg_en_mask[gi] | done_reg[gi] | out_fire[gi];
    end
  endgenerate

  assign tok_release = full & (&taken);
  assign in_ready_w  = ~flush & (~full | tok_release);
  assign in_fire     = bus.in_valid & in_ready_w;

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    done_next  = done_reg;
    count_next = count_reg;
    if (flush) begin
      // flush wins over load and release; a release in this cycle is not counted
      state_next = ST_EMPTY;
      done_next  = '0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_fire) begin
            state_next = ST_FULL;
            data_next  = bus.in_data;
            done_next  = '0;
          end
        end
        ST_FULL: begin
          if (tok_release) begin
            count_next = count_reg + 16'd1;
            done_next  = '0;
            if (in_fire) begin
              // back-to-back: the next token replaces the released one
              data_next = bus.in_data;
            end else begin
              state_next = ST_EMPTY;
            end
          end else begin
            done_next = done_reg | out_fire;
          end
        end
        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_reg <= ST_EMPTY;
      data_reg  <= '0;
      done_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
      count_reg <= count_next;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_data  = data_reg;
  assign bus.out_valid = out_valid_w;
  assign tok_count     = count_reg;
  assign busy          = full;

endmodule
